// File: rtl/instr_decode.sv
// Decode stage: accepts fetch words, owns the integer register file and issues one
// registered OP/OP_IMM bundle (or a bubble) to exec per cycle with a one-cycle RAW interlock.
module instr_decode #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic [31:0]     instr_pc,
    output logic            instr_ready,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [12:0]     offset,
    output logic [31:0]     pc,
    output logic [4:0]      rd,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      in_opc;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            hazard, accept;

    logic [6:0]      opcode_d, funct7_d;
    logic [2:0]      funct3_d;
    logic [XLEN-1:0] op1_d, op2_d;
    logic [12:0]     offset_d;
    logic [31:0]     pc_d;
    logic [4:0]      rd_d;
    logic            illegal_d;

    assign in_opc = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // Write-first bypass: exec's writeback lands in the same cycle we read.
    assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_addr == rs1) ? wb_data : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_addr == rs2) ? wb_data : regs[rs2];

    assign hazard = (opcode != 7'd0) && (rd != 5'd0) &&
                    ((rd == rs1) || ((in_opc == OPC_OP) && (rd == rs2)));
    assign instr_ready = !rst && !hazard;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        opcode_d  = '0;
        funct3_d  = '0;
        funct7_d  = '0;
        op1_d     = '0;
        op2_d     = '0;
        offset_d  = '0;
        pc_d      = '0;
        rd_d      = '0;
        illegal_d = 1'b0;
        if (accept) begin
            if (in_opc == OPC_OP) begin
                opcode_d = OPC_OP;
                funct3_d = instr[14:12];
                funct7_d = instr[31:25];
                op1_d    = rs1_val;
                op2_d    = rs2_val;
                pc_d     = instr_pc;
                rd_d     = instr[11:7];
            end else if (in_opc == OPC_OP_IMM) begin
                opcode_d = OPC_OP_IMM;
                funct3_d = instr[14:12];
                // Only shifts carry funct7; keeps ADDI from looking like SUB.
                if (instr[13:12] == 2'b01) funct7_d = instr[31:25];
                op1_d    = rs1_val;
                op2_d    = {{(XLEN-12){instr[31]}}, instr[31:20]};
                offset_d = {instr[31], instr[31:20]};
                pc_d     = instr_pc;
                rd_d     = instr[11:7];
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= '0;
            op1     <= '0;
            op2     <= '0;
            offset  <= '0;
            pc      <= '0;
            rd      <= '0;
            illegal <= 1'b0;
        end else begin
            opcode  <= opcode_d;
            funct3  <= funct3_d;
            funct7  <= funct7_d;
            op1     <= op1_d;
            op2     <= op2_d;
            offset  <= offset_d;
            pc      <= pc_d;
            rd      <= rd_d;
            illegal <= illegal_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: expected bundles are queued when a word is driven
// and compared after the clock edge that should issue them.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] instr_pc = '0;
    logic        instr_ready;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op1, op2;
    logic [12:0] offset;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [12:0] offset;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        illegal;
    } bundle_t;

    bundle_t sb[$];

    instr_decode dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .op1         (op1),
        .op2         (op2),
        .offset      (offset),
        .pc          (pc),
        .rd          (rd),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b, input logic [12:0] off,
                                   input logic [31:0] p, input logic [4:0] r);
        bundle_t x;
        x.opcode = opc; x.funct3 = f3; x.funct7 = f7; x.op1 = a; x.op2 = b;
        x.offset = off; x.pc = p; x.rd = r; x.illegal = 1'b0;
        return x;
    endfunction

    function automatic bundle_t bub(input logic ill);
        bundle_t x;
        x = '0;
        x.illegal = ill;
        return x;
    endfunction

    task automatic cmp_out(input string tag, input bundle_t e);
        chk({tag, ".opcode"}, {25'd0, opcode}, {25'd0, e.opcode});
        chk({tag, ".funct3"}, {29'd0, funct3}, {29'd0, e.funct3});
        chk({tag, ".funct7"}, {25'd0, funct7}, {25'd0, e.funct7});
        chk({tag, ".op1"}, op1, e.op1);
        chk({tag, ".op2"}, op2, e.op2);
        chk({tag, ".offset"}, {19'd0, offset}, {19'd0, e.offset});
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.illegal});
    endtask

    // One cycle: drive at negedge, check ready, queue expectation, compare after posedge.
    task automatic step(input string tag, input logic v, input logic [31:0] w,
                        input logic [31:0] p, input logic [4:0] wa, input logic [31:0] wd,
                        input logic exp_rdy, input bundle_t e);
        bundle_t got_e;
        @(negedge clk);
        instr_valid = v; instr = w; instr_pc = p; wb_addr = wa; wb_data = wd;
        #1;
        chk({tag, ".ready"}, {31'd0, instr_ready}, {31'd0, exp_rdy});
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            cmp_out(tag, got_e);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, instr_ready}, 32'd0);
        cmp_out("rst", bub(1'b0));
        @(negedge clk);
        rst = 1'b0;

        step("addi", 1, 32'h00500093, 32'h100, 0, 0, 1,
             mk(7'h13, 3'd0, 7'h00, 0, 5, 13'd5, 32'h100, 5'd1));
        step("add_stall", 1, 32'h00108133, 32'h104, 0, 0, 0, bub(1'b0));
        step("add_byp", 1, 32'h00108133, 32'h104, 5'd1, 32'd5, 1,
             mk(7'h33, 3'd0, 7'h00, 5, 5, 13'd0, 32'h104, 5'd2));
        step("srai", 1, 32'h4040D193, 32'h108, 0, 0, 1,
             mk(7'h13, 3'd5, 7'h20, 5, 32'h404, 13'h0404, 32'h108, 5'd3));
        step("addi_neg", 1, 32'hFFF08193, 32'h10C, 0, 0, 1,
             mk(7'h13, 3'd0, 7'h00, 5, 32'hFFFFFFFF, 13'h1FFF, 32'h10C, 5'd3));
        step("add_x0", 1, 32'h00000233, 32'h110, 5'd0, 32'hDEADBEEF, 1,
             mk(7'h33, 3'd0, 7'h00, 0, 0, 13'd0, 32'h110, 5'd4));
        step("addi_x7", 1, 32'h00300393, 32'h114, 5'd5, 32'h77, 1,
             mk(7'h13, 3'd0, 7'h00, 0, 3, 13'd3, 32'h114, 5'd7));
        step("add_rf", 1, 32'h00128333, 32'h118, 0, 0, 1,
             mk(7'h33, 3'd0, 7'h00, 32'h77, 5, 13'd0, 32'h118, 5'd6));
        step("rs2_stall", 1, 32'h00600433, 32'h11C, 0, 0, 0, bub(1'b0));
        step("rs2_byp", 1, 32'h00600433, 32'h11C, 5'd6, 32'h1234, 1,
             mk(7'h33, 3'd0, 7'h00, 0, 32'h1234, 13'd0, 32'h11C, 5'd8));
        step("lw_illegal", 1, 32'h0000A083, 32'h120, 0, 0, 1, bub(1'b1));
        step("after_ill", 1, 32'h00108493, 32'h124, 0, 0, 1,
             mk(7'h13, 3'd0, 7'h00, 5, 1, 13'd1, 32'h124, 5'd9));
        step("idle", 0, 32'h0, 32'h0, 0, 0, 1, bub(1'b0));
        step("pre_rst", 1, 32'h00700513, 32'h128, 0, 0, 1,
             mk(7'h13, 3'd0, 7'h00, 0, 7, 13'd7, 32'h128, 5'd10));

        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.ready", {31'd0, instr_ready}, 32'd0);
        cmp_out("midrst", bub(1'b0));
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1, 32'h00008133, 32'h12C, 0, 0, 1,
             mk(7'h33, 3'd0, 7'h00, 0, 0, 13'd0, 32'h12C, 5'd2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
Decode stage directly upstream of instr_exec. It accepts 32-bit instruction words from fetch over a valid/ready handshake and owns the 32x32 integer register file, written back from exec's reg_addr/reg_data. Each cycle it issues one registered bundle to exec: an OP/OP_IMM instruction, or a bubble (opcode 0). A one-cycle RAW interlock covers the exec latency.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, architectural register count (x0 hardwired to 0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  fetch presents instr/instr_pc
instr  in  32  instruction word
instr_pc  in  32  address of instr
instr_ready  out  1  decode accepts this cycle (combinational)
wb_addr  in  5  writeback register, from exec reg_addr (0 = no write)
wb_data  in  32  writeback data, from exec reg_data
opcode  out  7  to exec; 0 = bubble
funct3  out  3  to exec
funct7  out  7  to exec
op1  out  32  rs1 value
op2  out  32  rs2 value or sign-extended immediate
offset  out  13  immediate sign-extended to 13 bits
pc  out  32  pc of issued instruction
rd  out  5  destination register
illegal  out  1  one-cycle pulse: accepted word had an unsupported opcode

Behaviour:
- Reset (async): all outputs 0 (opcode 0 = bubble). All register-file entries 0. instr_ready 0 while rst is high.
- Register file: written on posedge when wb_addr != 0. x0 always reads 0. Operand reads are combinational, with write-first bypass: if wb_addr == rs and rs != 0, read wb_data.
- Transfer occurs at posedge when instr_valid && instr_ready. Output registers update on every posedge. No transfer means a bubble is issued: opcode=0, rd=0, other outputs don't-care (0 preferred).
- Hazard: asserted when the currently issued bundle has opcode != 0 and rd != 0, and rd equals rs1 of the incoming instruction, or equals rs2 when the incoming opcode is OP.
  - instr_ready = !rst && !hazard.
  - A hazard issues exactly one bubble. The next cycle the operand is read through the bypass, because exec has written reg_addr by then.
  - Fetch must hold instr stable while instr_ready is low.
- OP (0110011): funct3=instr[14:12], funct7=instr[31:25], op1=R[rs1], op2=R[rs2], offset=0, rd=instr[11:7].
- OP_IMM (0010011): op1=R[rs1], op2=sext(instr[31:20]), offset=sext13(instr[31:20]), rd=instr[11:7].
  - funct7=instr[31:25] only for funct3 001 (SLLI) or 101 (SRLI/SRAI).
  - Otherwise funct7=0, so ADDI is never executed as SUB.
- Any other opcode when accepted: consumed, issued as a bubble, illegal=1 for one cycle.
- rd=0 instructions are issued normally; exec's write is dropped by the register file.
- A reset mid-stream discards the issued bundle and clears the register file; there is no replay.
- pc = instr_pc of the accepted word.
- Latency: one cycle from accept to exec inputs. Throughput: 1/cycle without hazards, 1 per 2 cycles for back-to-back dependent instructions.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) valid -> next cycle opcode=0010011, funct3=0, funct7=0, op1=0, op2=5, offset=5, rd=1.
- 0x00500093 followed by ADD x2,x1,x1 (0x00108133), valid held -> instr_ready=0 for one cycle and a bubble is issued; with wb_addr=1, wb_data=5 the ADD issues op1=op2=5 (bypass).
- SRAI x3,x1,4 (0x4040D193) -> funct7=0100000, op2[4:0]=4. ADDI x3,x1,-1 (0xFFF08193) -> funct7=0, op2=0xFFFFFFFF, offset=0x1FFF.
- wb_addr=0 with wb_data=0xDEADBEEF, then ADD x4,x0,x0 -> op1=op2=0. Independent instructions back-to-back -> instr_ready stays 1 and one instruction is issued per cycle.
- Accepted LW word 0x0000A083 -> illegal pulses once, opcode=0 issued, next instruction accepted normally.
- Assert rst mid-stream after writing x1=5 -> outputs 0 immediately; a subsequent ADD x2,x1,x0 reads op1=0.
